// File: rtl/caesar_decoder_if.sv
// Byte-stream handshake between a producer, the Caesar decoder and its consumer.
// The master drives encoded bytes and takes decoded ones; the slave is the decoder.
interface caesar_decoder_if #(
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [7:0]    in_char;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    out_char;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   letter_count;
   logic [LW-1:0] level;

   modport master (
      output in_char, in_valid, out_ready,
      input  in_ready, out_char, out_valid, letter_count, level
   );

   modport slave (
      input  in_char, in_valid, out_ready,
      output in_ready, out_char, out_valid, letter_count, level
   );
endinterface

// File: rtl/caesar_decoder.sv
// Caesar decoder: rotates letters back by SHIFT as they are written and
// queues the decoded bytes in a DEPTH-entry FIFO; counts accepted letters.
module caesar_decoder #(
   parameter int SHIFT = 13,
   parameter int DEPTH = 4
) (
   input logic             clock,
   input logic             reset,
   caesar_decoder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);
   localparam logic [4:0]    SH5  = 5'(SHIFT);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [15:0]   count_q, count_d;
   logic          live_q;

   logic          in_ready, out_valid, push, pop;
   logic          is_upper, is_lower;
   logic [7:0]    base;
   logic [4:0]    off;
   logic [5:0]    rot;
   logic [7:0]    dec_char;

   // live_q keeps in_ready low until the first edge after reset release
   assign in_ready  = live_q && (level_q != FULL);
   assign out_valid = (level_q != '0);
   assign push      = bus.in_valid && in_ready;
   assign pop       = out_valid && bus.out_ready;

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = out_valid;
   assign bus.out_char     = out_valid ? mem_q[rptr_q] : '0;
   assign bus.level        = level_q;
   assign bus.letter_count = count_q;

   always_comb begin
      is_upper = (bus.in_char >= 8'h41) && (bus.in_char <= 8'h5A);
      is_lower = (bus.in_char >= 8'h61) && (bus.in_char <= 8'h7A);
      base     = is_upper ? 8'h41 : 8'h61;
      off      = 5'(bus.in_char - base);
      // 6-bit subtract; an underflow is folded back into 0..25 by adding 26
      rot      = {1'b0, off} - {1'b0, SH5};
      if (off < SH5) rot = rot + 6'd26;
      dec_char = (is_upper || is_lower) ? (base + {3'b000, rot[4:0]}) : bus.in_char;
   end

   always_comb begin
      wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
      level_d = level_q;
      if (push && !pop) level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
      count_d = (push && (is_upper || is_lower)) ? count_q + 16'd1 : count_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         live_q  <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         count_q <= '0;
      end else begin
         live_q  <= 1'b1;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wptr_q] <= dec_char;
   end
endmodule

// File: tb/tb_caesar_decoder.sv
// Directed bench for caesar_decoder: three instances (SHIFT 13, 3, 0) share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_caesar_decoder;
   localparam int DEPTH = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] in_char;
   logic       in_valid;
   logic       out_ready;

   int nvec = 0;
   int nerr = 0;

   always #5 clock = ~clock;

   caesar_decoder_if #(.DEPTH(DEPTH)) if13 ();
   caesar_decoder_if #(.DEPTH(DEPTH)) if3 ();
   caesar_decoder_if #(.DEPTH(DEPTH)) if0 ();

   assign if13.in_char = in_char;  assign if13.in_valid = in_valid;  assign if13.out_ready = out_ready;
   assign if3.in_char  = in_char;  assign if3.in_valid  = in_valid;  assign if3.out_ready  = out_ready;
   assign if0.in_char  = in_char;  assign if0.in_valid  = in_valid;  assign if0.out_ready  = out_ready;

   caesar_decoder #(.SHIFT(13), .DEPTH(DEPTH)) dut13 (.clock(clock), .reset(reset), .bus(if13.slave));
   caesar_decoder #(.SHIFT(3),  .DEPTH(DEPTH)) dut3  (.clock(clock), .reset(reset), .bus(if3.slave));
   caesar_decoder #(.SHIFT(0),  .DEPTH(DEPTH)) dut0  (.clock(clock), .reset(reset), .bus(if0.slave));

   int         shifts [3] = '{13, 3, 0};
   logic [7:0] och  [3];
   logic       oval [3];
   logic       ird  [3];
   logic [2:0] lvl  [3];
   logic [15:0] cnt [3];

   assign och[0] = if13.out_char;  assign oval[0] = if13.out_valid;  assign ird[0] = if13.in_ready;
   assign och[1] = if3.out_char;   assign oval[1] = if3.out_valid;   assign ird[1] = if3.in_ready;
   assign och[2] = if0.out_char;   assign oval[2] = if0.out_valid;   assign ird[2] = if0.in_ready;
   assign lvl[0] = if13.level;     assign lvl[1] = if3.level;        assign lvl[2] = if0.level;
   assign cnt[0] = if13.letter_count; assign cnt[1] = if3.letter_count; assign cnt[2] = if0.letter_count;

   // ---------------- model: queue of raw accepted bytes ----------------
   logic [7:0]  mq [$];
   int unsigned mcount = 0;
   bit          mlive  = 1'b0;
   bit          m_push, m_pop;

   function automatic bit m_letter(input logic [7:0] c);
      return (c >= 8'd65 && c <= 8'd90) || (c >= 8'd97 && c <= 8'd122);
   endfunction

   function automatic logic [7:0] m_dec(input logic [7:0] c, input int s);
      int v;
      v = int'(c);
      if (v >= 65 && v <= 90)  return 8'(65 + ((v - 65 - s + 26) % 26));
      if (v >= 97 && v <= 122) return 8'(97 + ((v - 97 - s + 26) % 26));
      return c;
   endfunction

   function automatic bit m_ready();
      return mlive && (mq.size() != DEPTH);
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mq.delete();
         mcount <= 0;
         mlive  <= 1'b0;
      end else begin
         m_push = in_valid && m_ready();
         m_pop  = (mq.size() != 0) && out_ready;
         if (m_pop) void'(mq.pop_front());
         if (m_push) begin
            mq.push_back(in_char);
            if (m_letter(in_char)) mcount <= (mcount + 1) % 65536;
         end
         mlive <= 1'b1;
      end
   end

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s dut%0d t=%0t got %0h want %0h", nm, d, $time, act, exp);
      end
   endtask

   always @(negedge clock) begin
      for (int d = 0; d < 3; d++) begin
         chk("in_ready",  d, 32'(ird[d]),  32'(m_ready()));
         chk("out_valid", d, 32'(oval[d]), 32'(mq.size() != 0));
         chk("level",     d, 32'(lvl[d]),  32'(mq.size()));
         chk("count",     d, 32'(cnt[d]),  32'(mcount));
         chk("out_char",  d, 32'(och[d]),  (mq.size() != 0) ? 32'(m_dec(mq[0], shifts[d])) : 32'h0);
      end
   end

   // ---------------- directed stimulus with literal expectations ----------------
   task automatic drive(input logic [7:0] c, input logic v);
      in_char  = c;
      in_valid = v;
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_char  = 'x;
      @(posedge clock);
      #1;
   endtask

   string s_in, s_out, s_out3, s_full;

   initial begin
      in_valid  = 1'b0;
      in_char   = 'x;
      out_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_in_ready",  0, 32'(if13.in_ready),     32'h0);
      chk("rst_out_valid", 0, 32'(if13.out_valid),    32'h0);
      chk("rst_level",     0, 32'(if13.level),        32'h0);
      chk("rst_count",     0, 32'(if13.letter_count), 32'h0);
      chk("rst_out_char",  0, 32'(if13.out_char),     32'h0);
      reset = 1'b1;
      #1 chk("ready_before_edge", 0, 32'(if13.in_ready), 32'h0);
      @(posedge clock); #1;
      chk("ready_after_edge", 0, 32'(if13.in_ready), 32'h1);

      // rot13 letters, one per cycle, out_ready held high
      s_in = "NnAz"; s_out = "AaNm";
      for (int i = 0; i < 4; i++) begin
         drive(s_in[i], 1'b1);
         chk("rot13_valid", 0, 32'(if13.out_valid), 32'h1);
         chk("rot13_char",  0, 32'(if13.out_char),  32'(s_out[i]));
      end
      idle();
      chk("rot13_count", 0, 32'(if13.letter_count), 32'd4);

      // non-letters at the letter-range edges pass through
      s_in = ".8@[`{";
      for (int i = 0; i < 6; i++) begin
         drive(s_in[i], 1'b1);
         chk("pass_char", 0, 32'(if13.out_char), 32'(s_in[i]));
      end
      idle();
      chk("pass_count", 0, 32'(if13.letter_count), 32'd4);

      // SHIFT=3 and SHIFT=0 instances
      s_in = "acAq"; s_out3 = "xzXn";
      for (int i = 0; i < 4; i++) begin
         drive(s_in[i], 1'b1);
         chk("shift3_char", 1, 32'(if3.out_char), 32'(s_out3[i]));
         chk("shift0_char", 2, 32'(if0.out_char), 32'(s_in[i]));
      end
      idle();

      // backpressure: fill, refuse a fifth byte, then drain in order
      out_ready = 1'b0;
      s_in = "NOPQ"; s_full = "ABCD";
      for (int i = 0; i < 4; i++) drive(s_in[i], 1'b1);
      chk("full_level", 0, 32'(if13.level),    32'd4);
      chk("full_ready", 0, 32'(if13.in_ready), 32'h0);
      drive(8'h52, 1'b1);
      chk("fifth_level", 0, 32'(if13.level), 32'd4);
      // pop while full with input still offered: no push that cycle
      out_ready = 1'b1;
      #1 chk("drain_0_char", 0, 32'(if13.out_char), 32'(s_full[0]));
      @(posedge clock); #1;
      in_valid = 1'b0;
      in_char  = 'x;
      chk("pop_full_level", 0, 32'(if13.level),    32'd3);
      chk("pop_full_ready", 0, 32'(if13.in_ready), 32'h1);
      for (int i = 1; i < 4; i++) begin
         chk("drain_char", 0, 32'(if13.out_char), 32'(s_full[i]));
         @(posedge clock); #1;
      end
      chk("drained_valid", 0, 32'(if13.out_valid), 32'h0);

      // reset mid-stream with three bytes buffered
      out_ready = 1'b0;
      s_in = "XYZ";
      for (int i = 0; i < 3; i++) drive(s_in[i], 1'b1);
      in_valid = 1'b0;
      chk("pre_rst_level", 0, 32'(if13.level), 32'd3);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_valid", 0, 32'(if13.out_valid), 32'h0);
      chk("mid_rst_level", 0, 32'(if13.level),     32'h0);
      chk("mid_rst_ready", 0, 32'(if13.in_ready),  32'h0);
      @(posedge clock); #3 reset = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b1;
      drive(8'h4E, 1'b1);
      chk("post_rst_char",  0, 32'(if13.out_char), 32'h41);
      chk("post_rst_level", 0, 32'(if13.level),    32'd1);
      idle();
      chk("post_rst_empty", 0, 32'(if13.out_valid), 32'h0);

      // letter_count wrap
      begin
         int n;
         n = 65535 - int'(if13.letter_count);
         for (int i = 0; i < n; i++) drive(8'h61, 1'b1);
      end
      chk("count_max",  0, 32'(if13.letter_count), 32'hFFFF);
      drive(8'h5A, 1'b1);
      chk("count_wrap", 0, 32'(if13.letter_count), 32'h0);
      idle();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/caesar_decoder.md
CAESAR_DECODER -- requirements
Module: caesar_decoder

Interface
REQ-001 Parameter SHIFT, default 13, is the rotation removed from letters; legal range 0..25.
REQ-002 Parameter DEPTH, default 4, is the number of output buffer entries; power of two, at least 2.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; the block is in reset while reset is 0.
REQ-005 in_char  input  8  encoded ASCII byte.
REQ-006 in_valid  input  1  in_char is presented.
REQ-007 in_ready  output  1  the block can accept a byte this cycle.
REQ-008 out_char  output  8  decoded ASCII byte at the buffer head.
REQ-009 out_valid  output  1  out_char holds a valid decoded byte.
REQ-010 out_ready  input  1  the consumer takes out_char this cycle.
REQ-011 letter_count  output  16  number of decoded bytes that were letters.
REQ-012 level  output  clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-013 Input transfer: occurs when in_valid and in_ready are both 1 at a rising edge.
REQ-014 Output transfer: occurs when out_valid and out_ready are both 1 at a rising edge.
REQ-015 Uppercase decode: for 'A'..'Z', the output is 'A' + ((c - 'A' - SHIFT) mod 26).
REQ-016 Lowercase decode: for 'a'..'z', the output is 'a' + ((c - 'a' - SHIFT) mod 26).
REQ-017 Non-letters pass through unchanged, including bytes 0x00-0x40, 0x5B-0x60 and 0x7B-0xFF.
REQ-018 Modulo arithmetic uses no wider than a 6-bit intermediate: subtract SHIFT, then add 26 on underflow; no division.
REQ-019 The decode is applied when the byte is written into the buffer; the buffer stores decoded bytes.
REQ-020 Buffer ordering is FIFO of DEPTH entries, with read and write pointers that wrap from DEPTH-1 to 0.
REQ-021 in_ready equals (level != DEPTH) and depends only on registered state, never on out_ready.
REQ-022 When full, no input transfer occurs even if an output transfer happens in the same cycle; in_ready rises the cycle after the pop.
REQ-023 out_valid equals (level != 0), and out_char is driven from the entry at the read pointer.
REQ-024 Latency: a byte accepted at edge N into an empty buffer has out_valid=1 after edge N, i.e. one cycle.
REQ-025 Simultaneous push and pop when 0 < level < DEPTH: level is unchanged and both pointers advance.
REQ-026 Push only: level increments by 1. Pop only: level decrements by 1.
REQ-027 When empty, out_ready is ignored, with no pointer or level change.
REQ-028 While out_valid=1 and out_ready=0, out_char holds stable.
REQ-029 letter_count increments by 1 on each input transfer whose in_char is a letter.
REQ-030 letter_count wraps from 0xFFFF to 0x0000 without saturation.
REQ-031 Values of in_char are don't-care when in_valid=0; X on in_char must not corrupt state.

Reset
REQ-032 While reset=0, these outputs are forced immediately, independent of clock: in_ready=0, out_valid=0, level=0, letter_count=0, out_char=0x00.
REQ-033 Reset also clears both pointers; buffer contents need not be cleared.
REQ-034 Reset asserted mid-stream discards all buffered bytes; no partial byte emerges after release.
REQ-035 in_ready rises on the first rising edge after reset returns to 1, not before.

Verification
REQ-036 SHIFT=13, out_ready=1: in 'N','n','A','z' one per cycle -> out 'A','a','N','m' on consecutive cycles, each one cycle after its input; letter_count=4.
REQ-037 SHIFT=13: in '.','8','@','[','`','{' -> out identical bytes; letter_count unchanged.
REQ-038 SHIFT=3: in 'a','c','A' -> out 'x','z','X'. SHIFT=0: 'q' -> 'q'.
REQ-039 DEPTH=4 backpressure: out_ready=0, push 'N','O','P','Q' -> level=4, in_ready=0, and a fifth byte is not accepted. Then out_ready=1 -> 'A','B','C','D' in order; in_ready=1 one cycle after the first pop.
REQ-040 Reset mid-operation: with level=3, drive reset=0 between edges -> out_valid=0 and level=0 immediately. After release, the next input 'N' produces 'A' with no stale bytes.
REQ-041 Counter wrap: force or stream 65535 letters, then one more letter -> letter_count reads 0x0000.
